// File: rtl/dcache_assoc.sv
// dcache_assoc: N-way set-associative per-core data cache between the LSU
// and the data memory controller. One word per line, one request in flight.
// Reads allocate on miss (victim = lowest invalid way, else the set's
// round-robin pointer). Writes are write-through, no-write-allocate; a write
// hit updates the cached word in place.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   lsu_read_*               LSU read request / address / valid / data
//   lsu_write_*              LSU write request / address / data / ack
//   mem_read_*               memory read valid / address / ready / data
//   mem_write_*              memory write valid / address / data / ready
//   stat_* (DCACHE_STATS_EN) 32-bit saturating read-hit / read-miss / write counters
//
// Optional feature: define DCACHE_STATS_EN to add the statistics outputs.
module dcache_assoc #(
   parameter int DATA_MEM_ADDR_BITS = 8,
   parameter int DATA_MEM_DATA_BITS = 8,
   parameter int NUM_SETS           = 8,
   parameter int NUM_WAYS           = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          lsu_read_request,
   input  logic [DATA_MEM_ADDR_BITS-1:0] lsu_read_address,
   output logic                          lsu_read_valid,
   output logic [DATA_MEM_DATA_BITS-1:0] lsu_read_data,
   input  logic                          lsu_write_request,
   input  logic [DATA_MEM_ADDR_BITS-1:0] lsu_write_address,
   input  logic [DATA_MEM_DATA_BITS-1:0] lsu_write_data,
   output logic                          lsu_write_ack,
   output logic                          mem_read_valid,
   output logic [DATA_MEM_ADDR_BITS-1:0] mem_read_address,
   input  logic                          mem_read_ready,
   input  logic [DATA_MEM_DATA_BITS-1:0] mem_read_data,
   output logic                          mem_write_valid,
   output logic [DATA_MEM_ADDR_BITS-1:0] mem_write_address,
   output logic [DATA_MEM_DATA_BITS-1:0] mem_write_data,
   input  logic                          mem_write_ready
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]                   stat_read_hits,
   output logic [31:0]                   stat_read_misses,
   output logic [31:0]                   stat_writes
`endif
);

   localparam int IDX_BITS = $clog2(NUM_SETS);
   localparam int TAG_BITS = DATA_MEM_ADDR_BITS - IDX_BITS;
   localparam int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_MISS = 3'd1;
   localparam logic [2:0] WR_MEM  = 3'd2;
   localparam logic [2:0] RESP_RD = 3'd3;
   localparam logic [2:0] RESP_WR = 3'd4;

   logic [2:0]                          state_q;
   logic [NUM_SETS-1:0][NUM_WAYS-1:0]   valid_q;
   logic [NUM_SETS-1:0][WAY_BITS-1:0]   rr_q;
   logic [TAG_BITS-1:0]                 tag_q  [NUM_SETS][NUM_WAYS];
   logic [DATA_MEM_DATA_BITS-1:0]       data_q [NUM_SETS][NUM_WAYS];

   logic                                rd_valid_q, wr_ack_q, mem_rd_valid_q, mem_wr_valid_q;
   logic [DATA_MEM_DATA_BITS-1:0]       rd_data_q, mem_wr_data_q;
   logic [DATA_MEM_ADDR_BITS-1:0]       mem_rd_addr_q, mem_wr_addr_q;

   // Lookup address: the incoming request in IDLE (read wins), otherwise the
   // outstanding miss address so the fill lands in the right set.
   logic [DATA_MEM_ADDR_BITS-1:0]       lk_addr;
   logic [IDX_BITS-1:0]                 lk_idx;
   logic [TAG_BITS-1:0]                 lk_tag;
   logic                                hit, any_inv;
   logic [WAY_BITS-1:0]                 hit_way, inv_way, victim;

   always_comb begin
      if (state_q == IDLE)
         lk_addr = lsu_read_request ? lsu_read_address : lsu_write_address;
      else
         lk_addr = mem_rd_addr_q;
   end
   assign lk_idx = lk_addr[IDX_BITS-1:0];
   assign lk_tag = lk_addr[DATA_MEM_ADDR_BITS-1:IDX_BITS];

   // Descending scan so the lowest-numbered invalid way wins.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      any_inv = 1'b0;
      inv_way = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
            hit     = 1'b1;
            hit_way = w[WAY_BITS-1:0];
         end
         if (!valid_q[lk_idx][w]) begin
            any_inv = 1'b1;
            inv_way = w[WAY_BITS-1:0];
         end
      end
      victim = any_inv ? inv_way : rr_q[lk_idx];
   end

   logic rd_hit_go, rd_miss_go, wr_go, fill_en, wr_hit_en;
   assign rd_hit_go  = (state_q == IDLE) && lsu_read_request && hit;
   assign rd_miss_go = (state_q == IDLE) && lsu_read_request && !hit;
   assign wr_go      = (state_q == IDLE) && !lsu_read_request && lsu_write_request;
   assign fill_en    = (state_q == RD_MISS) && mem_read_ready;
   assign wr_hit_en  = wr_go && hit;

   // Tag/data storage needs no reset: valid bits gate every use.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_q[lk_idx][victim]  <= lk_tag;
         data_q[lk_idx][victim] <= mem_read_data;
      end else if (wr_hit_en) begin
         data_q[lk_idx][hit_way] <= lsu_write_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         valid_q        <= '0;
         rr_q           <= '0;
         rd_valid_q     <= 1'b0;
         rd_data_q      <= '0;
         wr_ack_q       <= 1'b0;
         mem_rd_valid_q <= 1'b0;
         mem_rd_addr_q  <= '0;
         mem_wr_valid_q <= 1'b0;
         mem_wr_addr_q  <= '0;
         mem_wr_data_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rd_hit_go) begin
                  rd_data_q  <= data_q[lk_idx][hit_way];
                  rd_valid_q <= 1'b1;
                  state_q    <= RESP_RD;
               end else if (rd_miss_go) begin
                  mem_rd_addr_q  <= lsu_read_address;
                  mem_rd_valid_q <= 1'b1;
                  state_q        <= RD_MISS;
               end else if (wr_go) begin
                  mem_wr_addr_q  <= lsu_write_address;
                  mem_wr_data_q  <= lsu_write_data;
                  mem_wr_valid_q <= 1'b1;
                  state_q        <= WR_MEM;
               end
            end
            RD_MISS: begin
               if (mem_read_ready) begin
                  mem_rd_valid_q         <= 1'b0;
                  valid_q[lk_idx][victim] <= 1'b1;
                  // Pointer only advances when it actually chose the victim.
                  if (!any_inv && NUM_WAYS > 1)
                     rr_q[lk_idx] <= rr_q[lk_idx] + 1'b1;
                  rd_data_q  <= mem_read_data;
                  rd_valid_q <= 1'b1;
                  state_q    <= RESP_RD;
               end
            end
            WR_MEM: begin
               if (mem_write_ready) begin
                  mem_wr_valid_q <= 1'b0;
                  wr_ack_q       <= 1'b1;
                  state_q        <= RESP_WR;
               end
            end
            RESP_RD: begin
               if (!lsu_read_request) begin
                  rd_valid_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            RESP_WR: begin
               if (!lsu_write_request) begin
                  wr_ack_q <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign lsu_read_valid    = rd_valid_q;
   assign lsu_read_data     = rd_data_q;
   assign lsu_write_ack     = wr_ack_q;
   assign mem_read_valid    = mem_rd_valid_q;
   assign mem_read_address  = mem_rd_addr_q;
   assign mem_write_valid   = mem_wr_valid_q;
   assign mem_write_address = mem_wr_addr_q;
   assign mem_write_data    = mem_wr_data_q;

`ifdef DCACHE_STATS_EN
   logic [31:0] hits_q, misses_q, writes_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hits_q   <= '0;
         misses_q <= '0;
         writes_q <= '0;
      end else begin
         if (rd_hit_go  && hits_q   != 32'hFFFF_FFFF) hits_q   <= hits_q + 32'd1;
         if (rd_miss_go && misses_q != 32'hFFFF_FFFF) misses_q <= misses_q + 32'd1;
         if (wr_go      && writes_q != 32'hFFFF_FFFF) writes_q <= writes_q + 32'd1;
      end
   end
   assign stat_read_hits   = hits_q;
   assign stat_read_misses = misses_q;
   assign stat_writes      = writes_q;
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// Self-checking bench for dcache_assoc (default 8-bit / 8 sets / 4 ways).
// A behavioural memory answers reads/writes after a programmable delay;
// expected read data is queued when a read is issued and popped when the
// cache responds. Define DCACHE_STATS_EN to also check the counters.
module tb_dcache_assoc;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       lsu_read_request = 1'b0;
   logic [7:0] lsu_read_address = '0;
   logic       lsu_read_valid;
   logic [7:0] lsu_read_data;
   logic       lsu_write_request = 1'b0;
   logic [7:0] lsu_write_address = '0;
   logic [7:0] lsu_write_data = '0;
   logic       lsu_write_ack;
   logic       mem_read_valid;
   logic [7:0] mem_read_address;
   logic       mem_read_ready = 1'b0;
   logic [7:0] mem_read_data = '0;
   logic       mem_write_valid;
   logic [7:0] mem_write_address;
   logic [7:0] mem_write_data;
   logic       mem_write_ready = 1'b0;
`ifdef DCACHE_STATS_EN
   logic [31:0] stat_read_hits, stat_read_misses, stat_writes;
`endif

   dcache_assoc #(.DATA_MEM_ADDR_BITS(8), .DATA_MEM_DATA_BITS(8), .NUM_SETS(8), .NUM_WAYS(4)) dut (
      .clk(clk), .reset(reset),
      .lsu_read_request(lsu_read_request), .lsu_read_address(lsu_read_address),
      .lsu_read_valid(lsu_read_valid), .lsu_read_data(lsu_read_data),
      .lsu_write_request(lsu_write_request), .lsu_write_address(lsu_write_address),
      .lsu_write_data(lsu_write_data), .lsu_write_ack(lsu_write_ack),
      .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
      .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
      .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
      .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
`ifdef DCACHE_STATS_EN
      , .stat_read_hits(stat_read_hits), .stat_read_misses(stat_read_misses), .stat_writes(stat_writes)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // ---------------- memory model ----------------
   logic [7:0] mem [256];
   int         rd_delay = 3;
   int         wr_delay = 2;
   int         rcnt = 0, wcnt = 0;
   int         rd_txn = 0, wr_txn = 0, overlap = 0;
   logic [7:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;

   always @(negedge clk) begin
      if (mem_read_valid && mem_write_valid) overlap++;
      if (!mem_read_valid || mem_read_ready) begin
         mem_read_ready = 1'b0;
         rcnt = 0;
      end else begin
         rcnt++;
         if (rcnt >= rd_delay) begin
            mem_read_ready = 1'b1;
            mem_read_data  = mem[mem_read_address];
            last_rd_addr   = mem_read_address;
            rd_txn++;
         end
      end
      if (!mem_write_valid || mem_write_ready) begin
         mem_write_ready = 1'b0;
         wcnt = 0;
      end else begin
         wcnt++;
         if (wcnt >= wr_delay) begin
            mem_write_ready = 1'b1;
            mem[mem_write_address] = mem_write_data;
            last_wr_addr = mem_write_address;
            last_wr_data = mem_write_data;
            wr_txn++;
         end
      end
   end

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q [$];

   // Drivers only: they return what they observed; the scenarios compare.
   task automatic do_read(input logic [7:0] a, output logic [7:0] d, output int lat,
                          output int txn, output bit to);
      int r0;
      r0 = rd_txn;
      @(negedge clk);
      lsu_read_request = 1'b1;
      lsu_read_address = a;
      lat = 0;
      to  = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         lat++;
         if (lsu_read_valid) begin to = 1'b0; break; end
      end
      d   = lsu_read_data;
      txn = rd_txn - r0;
      lsu_read_request = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!lsu_read_valid) break;
      end
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] v, output int txn, output bit to);
      int w0;
      w0 = wr_txn;
      @(negedge clk);
      lsu_write_request = 1'b1;
      lsu_write_address = a;
      lsu_write_data    = v;
      to = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (lsu_write_ack) begin to = 1'b0; break; end
      end
      txn = wr_txn - w0;
      lsu_write_request = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!lsu_write_ack) break;
      end
   endtask

   // Issue a read, compare popped scoreboard entry and memory traffic.
   task automatic sb_read(input string nm, input logic [7:0] a, input logic [7:0] e, input int exp_txn);
      logic [7:0] d, want;
      int lat, txn;
      bit to;
      exp_q.push_back(e);
      do_read(a, d, lat, txn, to);
      want = exp_q.pop_front();
      n_cmp++;
      if (to) begin
         n_err++; $display("FAIL %s timeout: no lsu_read_valid", nm);
      end else if (d !== want) begin
         n_err++; $display("FAIL %s data: got %02h want %02h", nm, d, want);
      end
      n_cmp++;
      if (txn !== exp_txn) begin
         n_err++; $display("FAIL %s mem reads: got %0d want %0d", nm, txn, exp_txn);
      end
      if (exp_txn == 0) begin
         n_cmp++;
         if (lat !== 1) begin
            n_err++; $display("FAIL %s hit latency: got %0d want 1", nm, lat);
         end
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      lsu_read_request  = 1'b0;
      lsu_write_request = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({lsu_read_valid, lsu_read_data, lsu_write_ack, mem_read_valid, mem_read_address,
           mem_write_valid, mem_write_address, mem_write_data} !== '0) begin
         n_err++; $display("FAIL reset outputs: got rv=%b rd=%02h ack=%b mrv=%b mra=%02h mwv=%b mwa=%02h mwd=%02h want all 0",
                           lsu_read_valid, lsu_read_data, lsu_write_ack, mem_read_valid, mem_read_address,
                           mem_write_valid, mem_write_address, mem_write_data);
      end
`ifdef DCACHE_STATS_EN
      n_cmp++;
      if ({stat_read_hits, stat_read_misses, stat_writes} !== '0) begin
         n_err++; $display("FAIL reset stats: got %0d/%0d/%0d want 0/0/0", stat_read_hits, stat_read_misses, stat_writes);
      end
`endif
      reset = 1'b0;
   endtask

   task automatic test_reset();
      pulse_reset();
   endtask

   task automatic test_read_miss_hit();
      sb_read("read_miss_13", 8'h13, 8'hA5, 1);
      n_cmp++;
      if (last_rd_addr !== 8'h13) begin
         n_err++; $display("FAIL read_miss_13 mem addr: got %02h want 13", last_rd_addr);
      end
      sb_read("read_hit_13", 8'h13, 8'hA5, 0);
   endtask

   task automatic test_write_hit();
      int txn;
      bit to;
      do_write(8'h13, 8'h5A, txn, to);
      n_cmp++;
      if (to || txn !== 1 || last_wr_addr !== 8'h13 || last_wr_data !== 8'h5A) begin
         n_err++; $display("FAIL write_hit mem write: got to=%b n=%0d a=%02h d=%02h want 0/1/13/5a",
                           to, txn, last_wr_addr, last_wr_data);
      end
      sb_read("read_after_write_13", 8'h13, 8'h5A, 0);
   endtask

   task automatic test_write_miss();
      int txn;
      bit to;
      do_write(8'h40, 8'h77, txn, to);
      n_cmp++;
      if (to || txn !== 1 || last_wr_addr !== 8'h40 || last_wr_data !== 8'h77) begin
         n_err++; $display("FAIL write_miss mem write: got to=%b n=%0d a=%02h d=%02h want 0/1/40/77",
                           to, txn, last_wr_addr, last_wr_data);
      end
      sb_read("read_after_nwa_40", 8'h40, 8'h77, 1);
   endtask

   task automatic test_eviction();
      logic [7:0] addrs [5];
      addrs = '{8'h03, 8'h0B, 8'h13, 8'h1B, 8'h23};
      pulse_reset();
      foreach (addrs[i]) sb_read($sformatf("fill_%02h", addrs[i]), addrs[i], mem[addrs[i]], 1);
      sb_read("evicted_03", 8'h03, mem[8'h03], 1);   // refills way 1, evicting 0x0B
      sb_read("kept_13", 8'h13, mem[8'h13], 0);
      sb_read("kept_23", 8'h23, mem[8'h23], 0);
      sb_read("evicted_0b", 8'h0B, mem[8'h0B], 1);
`ifdef DCACHE_STATS_EN
      n_cmp++;
      if (stat_read_hits !== 32'd2 || stat_read_misses !== 32'd7 || stat_writes !== 32'd0) begin
         n_err++; $display("FAIL evict stats: got %0d/%0d/%0d want 2/7/0", stat_read_hits, stat_read_misses, stat_writes);
      end
`endif
   endtask

   task automatic test_back_to_back();
      int t_rd, t_ack, ov0;
      logic [7:0] d, want;
      ov0 = overlap;
      t_rd = -1;
      t_ack = -1;
      exp_q.push_back(8'h10 ^ 8'h3C);
      @(negedge clk);
      lsu_read_request  = 1'b1;
      lsu_read_address  = 8'h10;
      lsu_write_request = 1'b1;
      lsu_write_address = 8'h20;
      lsu_write_data    = 8'h99;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (lsu_read_valid && t_rd < 0) begin
            t_rd = i;
            d = lsu_read_data;
            lsu_read_request = 1'b0;
         end
         if (lsu_write_ack && t_ack < 0) begin
            t_ack = i;
            lsu_write_request = 1'b0;
         end
         if (t_ack >= 0 && !lsu_write_ack) break;
      end
      lsu_read_request  = 1'b0;
      lsu_write_request = 1'b0;
      want = exp_q.pop_front();
      n_cmp++;
      if (t_rd < 0 || d !== want) begin
         n_err++; $display("FAIL b2b read data: got %02h (t=%0d) want %02h", d, t_rd, want);
      end
      n_cmp++;
      if (t_ack < 0 || t_rd < 0 || t_ack <= t_rd) begin
         n_err++; $display("FAIL b2b order: read at %0d ack at %0d, want read first", t_rd, t_ack);
      end
      n_cmp++;
      if (last_wr_addr !== 8'h20 || last_wr_data !== 8'h99) begin
         n_err++; $display("FAIL b2b mem write: got %02h/%02h want 20/99", last_wr_addr, last_wr_data);
      end
      n_cmp++;
      if (overlap !== ov0) begin
         n_err++; $display("FAIL b2b valid overlap: got %0d cycles want 0", overlap - ov0);
      end
   endtask

   task automatic test_reset_mid_miss();
      bit seen;
      rd_delay = 10;
      seen = 1'b0;
      @(negedge clk);
      lsu_read_request = 1'b1;
      lsu_read_address = 8'h50;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_read_valid) begin seen = 1'b1; break; end
      end
      n_cmp++;
      if (!seen) begin
         n_err++; $display("FAIL mid_miss: mem_read_valid got 0 want 1");
      end
      repeat (2) @(negedge clk);
      pulse_reset();
      rd_delay = 3;
      sb_read("after_reset_50", 8'h50, mem[8'h50], 1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
      mem[8'h13] = 8'hA5;
      repeat (2) @(negedge clk);
      test_reset();
      test_read_miss_hit();
      test_write_hit();
      test_write_miss();
      test_eviction();
      test_back_to_back();
      test_reset_mid_miss();
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
